usb_hub_port_repeater: RTL and testbench



---
 rtl/usb_hub_port_repeater.sv | 239 +++++++++++++++++++++++
 tb/tb_usb_hub_port_repeater.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_hub_port_repeater.sv
// Full-speed USB hub packet repeater: host packets go to all eligible downstream ports, one arbitrated port goes upstream.
// Optional babble disconnect is built when USB_HUB_BABBLE_DETECT_EN is defined.
module usb_hub_port_repeater #(
    parameter int NUM_USB_DEVICES = 2,
    parameter int MAX_PKT_BITS    = 1500,
    parameter int TURNAROUND_BITS = 4,
    localparam int AP_W = (NUM_USB_DEVICES > 1) ? $clog2(NUM_USB_DEVICES) : 1
) (
    input  logic                           hi_clock,
    input  logic                           reset_n,
    input  logic                           bit_en,
    input  logic [NUM_USB_DEVICES-1:0]     port_enable,
    input  logic [1:0]                     host_line,
    output logic                           host_drive_en,
    output logic [1:0]                     host_drive,
    input  logic [2*NUM_USB_DEVICES-1:0]   dev_line,
    output logic [NUM_USB_DEVICES-1:0]     dev_drive_en,
    output logic [2*NUM_USB_DEVICES-1:0]   dev_drive,
    output logic [AP_W-1:0]                active_port,
    output logic [NUM_USB_DEVICES-1:0]     port_babble,
    output logic [2:0]                     hub_state
);

    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;
    localparam int TURN_W = (TURNAROUND_BITS > 1) ? $clog2(TURNAROUND_BITS) : 1;
    localparam logic [2*NUM_USB_DEVICES-1:0] ALL_J = {NUM_USB_DEVICES{LINE_J}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DOWN  = 3'd1,
        ST_UP    = 3'd2,
        ST_EOP_J = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    // SE1 is illegal on the wire; it is repeated and counted as SE0.
    function automatic logic [1:0] norm_line(input logic [1:0] l);
        return (l == LINE_SE1) ? LINE_SE0 : l;
    endfunction

    state_t                          state_r;
    logic [NUM_USB_DEVICES-1:0]      down_mask_r;
    logic                            se0_seen_r;
    logic                            forcing_r;
    logic [1:0]                      force_cnt_r;
    logic [TURN_W-1:0]               turn_cnt_r;
    logic [AP_W-1:0]                 active_port_r;
    logic                            host_drive_en_r;
    logic [1:0]                      host_drive_r;
    logic [NUM_USB_DEVICES-1:0]      dev_drive_en_r;
    logic [2*NUM_USB_DEVICES-1:0]    dev_drive_r;

    logic [NUM_USB_DEVICES-1:0]      babble_s;
    logic [NUM_USB_DEVICES-1:0]      eligible_s;
    logic                            arb_found_s;
    logic [AP_W-1:0]                 arb_idx_s;
    logic [1:0]                      host_src_s;
    logic [1:0]                      up_src_s;
    logic                            active_en_s;
    logic [2*NUM_USB_DEVICES-1:0]    sop_drive_s;
    logic [2*NUM_USB_DEVICES-1:0]    down_drive_s;

`ifdef USB_HUB_BABBLE_DETECT_EN
    localparam int PKT_W = $clog2(MAX_PKT_BITS + 1);
    logic [PKT_W-1:0]                pkt_cnt_r;
    logic [NUM_USB_DEVICES-1:0]      port_babble_r;
    logic [NUM_USB_DEVICES-1:0]      en_prev_r;
    assign babble_s = port_babble_r;
`else
    assign babble_s = {NUM_USB_DEVICES{1'b0}};
`endif

    assign eligible_s  = port_enable & ~babble_s;
    assign host_src_s  = norm_line(host_line);
    assign up_src_s    = norm_line(dev_line[{active_port_r, 1'b0} +: 2]);
    assign active_en_s = port_enable[active_port_r];

    assign host_drive_en = host_drive_en_r;
    assign host_drive    = host_drive_r;
    assign dev_drive_en  = dev_drive_en_r;
    assign dev_drive     = dev_drive_r;
    assign active_port   = active_port_r;
    assign port_babble   = babble_s;
    assign hub_state     = state_r;

    // Lowest-index eligible port showing K wins upstream arbitration.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = {AP_W{1'b0}};
        for (int i = NUM_USB_DEVICES - 1; i >= 0; i--) begin
            if (eligible_s[i] && (dev_line[2*i +: 2] == LINE_K)) begin
                arb_found_s = 1'b1;
                arb_idx_s   = AP_W'(i);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Per-port drive values for the SOP bit and for continued downstream forwarding.
    always_comb begin
        sop_drive_s  = ALL_J;
        down_drive_s = ALL_J;
        for (int i = 0; i < NUM_USB_DEVICES; i++) begin
            sop_drive_s[2*i +: 2]  = eligible_s[i]  ? LINE_K : LINE_J;
            down_drive_s[2*i +: 2] = down_mask_r[i] ? host_src_s : LINE_J;
        end
    end

    // Repeater FSM: every counter and registered output advances once per bit strobe.
    always_ff @(posedge hi_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            down_mask_r     <= {NUM_USB_DEVICES{1'b0}};
            se0_seen_r      <= 1'b0;
            forcing_r       <= 1'b0;
            force_cnt_r     <= 2'd0;
            turn_cnt_r      <= {TURN_W{1'b0}};
            active_port_r   <= {AP_W{1'b0}};
            host_drive_en_r <= 1'b0;
            host_drive_r    <= LINE_J;
            dev_drive_en_r  <= {NUM_USB_DEVICES{1'b0}};
            dev_drive_r     <= ALL_J;
`ifdef USB_HUB_BABBLE_DETECT_EN
            pkt_cnt_r       <= {PKT_W{1'b0}};
            port_babble_r   <= {NUM_USB_DEVICES{1'b0}};
            en_prev_r       <= {NUM_USB_DEVICES{1'b0}};
`endif
        end else if (bit_en) begin
`ifdef USB_HUB_BABBLE_DETECT_EN
            // A falling port_enable edge is the only way (besides reset) to re-admit a babbler.
            en_prev_r     <= port_enable;
            port_babble_r <= port_babble_r & ~(en_prev_r & ~port_enable);
`endif
            case (state_r)
                ST_IDLE: begin
                    se0_seen_r  <= 1'b0;
                    forcing_r   <= 1'b0;
                    force_cnt_r <= 2'd0;
                    if (host_line == LINE_K) begin
                        state_r        <= ST_DOWN;
                        down_mask_r    <= eligible_s;
                        dev_drive_en_r <= eligible_s;
                        dev_drive_r    <= sop_drive_s;
                    end else if (arb_found_s) begin
                        state_r         <= ST_UP;
                        active_port_r   <= arb_idx_s;
                        host_drive_en_r <= 1'b1;
                        host_drive_r    <= LINE_K;
`ifdef USB_HUB_BABBLE_DETECT_EN
                        pkt_cnt_r       <= PKT_W'(1);
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DOWN: begin
                    dev_drive_r <= down_drive_s;
                    if (host_src_s == LINE_SE0) begin
                        se0_seen_r <= 1'b1;
                    end else if ((host_src_s == LINE_J) && se0_seen_r) begin
                        se0_seen_r <= 1'b0;
                        state_r    <= ST_EOP_J;
                    end else begin
                        se0_seen_r <= 1'b0;
                    end
                end
                ST_UP: begin
                    if (forcing_r) begin
                        // Hub-generated EOP: SE0, SE0, J.
                        if (force_cnt_r == 2'd1) begin
                            host_drive_r <= LINE_J;
                            forcing_r    <= 1'b0;
                            force_cnt_r  <= 2'd0;
                            state_r      <= ST_EOP_J;
                        end else begin
                            host_drive_r <= LINE_SE0;
                            force_cnt_r  <= force_cnt_r + 2'd1;
                        end
                    end else if (!active_en_s) begin
                        host_drive_r <= LINE_SE0;
                        forcing_r    <= 1'b1;
                        force_cnt_r  <= 2'd0;
`ifdef USB_HUB_BABBLE_DETECT_EN
                    end else if (pkt_cnt_r >= PKT_W'(MAX_PKT_BITS)) begin
                        host_drive_r                 <= LINE_SE0;
                        forcing_r                    <= 1'b1;
                        force_cnt_r                  <= 2'd0;
                        port_babble_r[active_port_r] <= 1'b1;
`endif
                    end else begin
                        host_drive_r <= up_src_s;
`ifdef USB_HUB_BABBLE_DETECT_EN
                        pkt_cnt_r    <= pkt_cnt_r + PKT_W'(1);
`endif
                        if (up_src_s == LINE_SE0) begin
                            se0_seen_r <= 1'b1;
                        end else if ((up_src_s == LINE_J) && se0_seen_r) begin
                            se0_seen_r <= 1'b0;
                            state_r    <= ST_EOP_J;
                        end else begin
                            se0_seen_r <= 1'b0;
                        end
                    end
                end
                ST_EOP_J: begin
                    host_drive_en_r <= 1'b0;
                    host_drive_r    <= LINE_J;
                    dev_drive_en_r  <= {NUM_USB_DEVICES{1'b0}};
                    dev_drive_r     <= ALL_J;
                    turn_cnt_r      <= {TURN_W{1'b0}};
                    state_r         <= ST_TURN;
                end
                ST_TURN: begin
                    // Line activity is deliberately ignored until the bus has settled.
                    if ((int'(turn_cnt_r) + 1) >= TURNAROUND_BITS) begin
                        turn_cnt_r <= {TURN_W{1'b0}};
                        state_r    <= ST_IDLE;
                    end else begin
                        turn_cnt_r <= turn_cnt_r + TURN_W'(1);
                    end
                end
                default: begin
                    host_drive_en_r <= 1'b0;
                    host_drive_r    <= LINE_J;
                    dev_drive_en_r  <= {NUM_USB_DEVICES{1'b0}};
                    dev_drive_r     <= ALL_J;
                    state_r         <= ST_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_usb_hub_port_repeater.sv
// Self-checking bench for usb_hub_port_repeater: directed steps with randomized packets and a packet-level model.
module tb_usb_hub_port_repeater;
    localparam int N     = 2;
    localparam int MAXB  = 16;
    localparam int TURNB = 4;
    localparam logic [1:0] J = 2'b01, K = 2'b10, SE0 = 2'b00, SE1 = 2'b11;

    logic           hi_clock = 1'b0;
    logic           reset_n;
    logic           bit_en;
    logic [N-1:0]   port_enable;
    logic [1:0]     host_line;
    logic           host_drive_en;
    logic [1:0]     host_drive;
    logic [2*N-1:0] dev_line;
    logic [N-1:0]   dev_drive_en;
    logic [2*N-1:0] dev_drive;
    logic [0:0]     active_port;
    logic [N-1:0]   port_babble;
    logic [2:0]     hub_state;

    int n_assert = 0;
    int n_fail   = 0;
    logic [1:0] pkt_q[$];
    logic [N-1:0] exp_babble = '0;

    usb_hub_port_repeater #(.NUM_USB_DEVICES(N), .MAX_PKT_BITS(MAXB), .TURNAROUND_BITS(TURNB)) dut (
        .hi_clock(hi_clock), .reset_n(reset_n), .bit_en(bit_en), .port_enable(port_enable),
        .host_line(host_line), .host_drive_en(host_drive_en), .host_drive(host_drive),
        .dev_line(dev_line), .dev_drive_en(dev_drive_en), .dev_drive(dev_drive),
        .active_port(active_port), .port_babble(port_babble), .hub_state(hub_state));

    always #5 hi_clock = ~hi_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] norm(input logic [1:0] l);
        return (l == SE1) ? SE0 : l;
    endfunction

    // Expected downstream drive: masked ports carry the symbol, the rest idle at J.
    function automatic logic [2*N-1:0] dev_vec(input logic [N-1:0] mask, input logic [1:0] sym);
        logic [2*N-1:0] v;
        for (int i = 0; i < N; i++) v[2*i +: 2] = mask[i] ? norm(sym) : J;
        return v;
    endfunction

    function automatic logic [1:0] rand_line();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? J : ((r == 1) ? K : SE0);
    endfunction

    // One bit strobe, then a random number of clocks with bit_en low.
    task automatic tick();
        bit_en = 1'b1;
        @(posedge hi_clock); #1;
        bit_en = 1'b0;
        repeat ($urandom_range(0, 1)) begin
            @(posedge hi_clock); #1;
        end
    endtask

    task automatic gen_pkt(input int body);
        int ne;
        pkt_q = {};
        pkt_q.push_back(K);
        for (int i = 0; i < body; i++) pkt_q.push_back(($urandom_range(0, 1) == 1) ? K : J);
        ne = $urandom_range(1, 3);
        for (int i = 0; i < ne; i++) pkt_q.push_back(($urandom_range(0, 3) == 0) ? SE1 : SE0);
        pkt_q.push_back(J);
    endtask

    // Turnaround: any SOP is ignored, IDLE only after TURNB strobes.
    task automatic finish_turn();
        for (int t = 1; t <= TURNB; t++) begin
            dev_line[3:2] = K;
            host_line     = ($urandom_range(0, 1) == 1) ? K : J;
            tick();
            chk("turn_state", 32'(hub_state), (t < TURNB) ? 32'd4 : 32'd0);
            chk("turn_drv_en", 32'({host_drive_en, dev_drive_en}), 32'd0);
        end
        host_line = J;
        dev_line  = {J, J};
    endtask

    // Sends pkt_q from the host (up=0) or device src (up=1); kmask ports show K on the SOP strobe.
    task automatic run_pkt(input bit up, input int src, input logic [N-1:0] kmask, input logic [N-1:0] en_mid);
        int L;
        logic [N-1:0] mask;
        logic [1:0] sym;
        L    = pkt_q.size();
        mask = port_enable & ~exp_babble;
        for (int s = 0; s < L; s++) begin
            sym = pkt_q[s];
            if (s == 0) begin
                for (int i = 0; i < N; i++) dev_line[2*i +: 2] = kmask[i] ? K : J;
                if (up) host_line = J; else host_line = sym;
            end else if (up) begin
                for (int i = 0; i < N; i++) dev_line[2*i +: 2] = rand_line();
                dev_line[2*src +: 2] = sym;
            end else begin
                dev_line  = {J, J};
                host_line = sym;
            end
            if (s == 1) port_enable = en_mid;
            tick();
            chk("pkt_state", 32'(hub_state), (s == L - 1) ? 32'd3 : (up ? 32'd2 : 32'd1));
            if (up) begin
                chk("up_drv_en", 32'(host_drive_en), 32'd1);
                chk("up_drv", 32'(host_drive), 32'(norm(sym)));
                chk("up_port", 32'(active_port), 32'(src));
                chk("up_dev_en", 32'(dev_drive_en), 32'd0);
            end else begin
                chk("dn_drv_en", 32'(dev_drive_en), 32'(mask));
                chk("dn_drv", 32'(dev_drive), 32'(dev_vec(mask, sym)));
                chk("dn_host_en", 32'(host_drive_en), 32'd0);
            end
        end
        host_line = J;
        dev_line  = {J, J};
        tick();
        chk("rel_state", 32'(hub_state), 32'd4);
        chk("rel_en", 32'({host_drive_en, dev_drive_en}), 32'd0);
        chk("rel_drv", 32'({host_drive, dev_drive}), 32'({J, J, J}));
        chk("babble", 32'(port_babble), 32'(exp_babble));
        finish_turn();
    endtask

    initial begin
        logic [N-1:0] en, km, em;
        int win;
        reset_n = 1'b0; bit_en = 1'b0; port_enable = 2'b11; host_line = J; dev_line = {J, J};
        repeat (3) @(posedge hi_clock);
        #1;
        chk("rst_state", 32'(hub_state), 32'd0);
        chk("rst_en", 32'({host_drive_en, dev_drive_en}), 32'd0);
        chk("rst_drv", 32'({host_drive, dev_drive}), 32'({J, J, J}));
        chk("rst_port", 32'(active_port), 32'd0);
        chk("rst_babble", 32'(port_babble), 32'd0);
        reset_n = 1'b1;
        @(posedge hi_clock); #1;

        // Directed host packet to both ports.
        pkt_q = {K, J, K, SE0, SE0, J};
        run_pkt(1'b0, 0, 2'b00, 2'b11);
        // Ports 0 and 1 request together: port 0 wins.
        pkt_q = {K, J, K, J, SE0, SE0, J};
        run_pkt(1'b1, 0, 2'b11, 2'b11);
        // Host SOP and device 0 SOP together: downstream wins.
        gen_pkt(4);
        run_pkt(1'b0, 0, 2'b01, 2'b11);
        // Disabled port 0 is not arbitrated.
        port_enable = 2'b10; dev_line = {J, K};
        tick();
        chk("dis_state", 32'(hub_state), 32'd0);
        chk("dis_host_en", 32'(host_drive_en), 32'd0);
        gen_pkt(3);
        run_pkt(1'b1, 1, 2'b11, 2'b10);

        // Randomized downstream/upstream packets.
        for (int it = 0; it < 10; it++) begin
            en = N'($urandom_range(0, 3));
            port_enable = en;
            gen_pkt($urandom_range(2, 9));
            if ($urandom_range(0, 1) == 1) begin
                run_pkt(1'b0, 0, N'($urandom_range(0, 3)), N'($urandom_range(0, 3)));
            end else begin
                km  = N'($urandom_range(1, 3));
                win = -1;
                for (int i = N - 1; i >= 0; i--) if (en[i] && km[i]) win = i;
                if (win < 0) begin
                    for (int i = 0; i < N; i++) dev_line[2*i +: 2] = km[i] ? K : J;
                    tick();
                    chk("noarb_state", 32'(hub_state), 32'd0);
                    chk("noarb_en", 32'(host_drive_en), 32'd0);
                    dev_line = {J, J};
                end else begin
                    em = N'($urandom_range(0, 3));
                    em[win] = 1'b1;
                    run_pkt(1'b1, win, km, em);
                end
            end
        end

        // Active port disabled mid-packet: forced SE0, SE0, J.
        port_enable = 2'b11;
        dev_line[3:2] = K;
        tick();
        chk("drop_up", 32'({hub_state, active_port}), 32'({3'd2, 1'b1}));
        dev_line[3:2] = J; tick();
        chk("drop_fwd", 32'(host_drive), 32'(J));
        port_enable = 2'b01; dev_line[3:2] = K; tick();
        chk("drop_se0a", 32'({hub_state, host_drive}), 32'({3'd2, SE0}));
        dev_line[3:2] = J; tick();
        chk("drop_se0b", 32'({hub_state, host_drive}), 32'({3'd2, SE0}));
        tick();
        chk("drop_j", 32'({hub_state, host_drive_en, host_drive}), 32'({3'd3, 1'b1, J}));
        tick();
        chk("drop_rel", 32'({hub_state, host_drive_en, host_drive}), 32'({3'd4, 1'b0, J}));
        finish_turn();
        port_enable = 2'b11;

`ifdef USB_HUB_BABBLE_DETECT_EN
        for (int s = 1; s <= 20; s++) begin
            dev_line[1:0] = (s % 2 == 1) ? K : J;
            tick();
            if (s <= MAXB) chk("bab_fwd", 32'({hub_state, host_drive}), 32'({3'd2, dev_line[1:0]}));
            else if (s <= MAXB + 2) chk("bab_se0", 32'({hub_state, host_drive}), 32'({3'd2, SE0}));
            else if (s == MAXB + 3) chk("bab_j", 32'({hub_state, host_drive}), 32'({3'd3, J}));
            else chk("bab_rel", 32'({hub_state, host_drive_en}), 32'({3'd4, 1'b0}));
            if (s == MAXB + 1) begin
                exp_babble = 2'b01;
                chk("bab_flag", 32'(port_babble), 32'(exp_babble));
            end
        end
        finish_turn();
        dev_line[1:0] = K; tick();
        chk("bab_block", 32'({hub_state, host_drive_en}), 32'({3'd0, 1'b0}));
        dev_line[1:0] = J; port_enable = 2'b10; tick();
        exp_babble = 2'b00;
        chk("bab_clear", 32'(port_babble), 32'(exp_babble));
        port_enable = 2'b11; tick();
        gen_pkt(5);
        run_pkt(1'b1, 0, 2'b01, 2'b11);
`endif

        // Asynchronous reset in the middle of an upstream packet.
        dev_line[3:2] = K; tick();
        chk("prerst_port", 32'(active_port), 32'd1);
        dev_line[3:2] = J; tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(hub_state), 32'd0);
        chk("arst_host", 32'({host_drive_en, host_drive}), 32'({1'b0, J}));
        chk("arst_port", 32'(active_port), 32'd0);
        dev_line = {J, J};
        @(posedge hi_clock); #1;
        reset_n = 1'b1;
        @(posedge hi_clock); #1;
        gen_pkt(6);
        run_pkt(1'b0, 0, 2'b00, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
